// File: rtl/periph_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : periph_bus_arbiter_if
// Purpose  : requester-side and downstream-side signals of the peripheral arbiter
// Revision : 1.0
// ============================================================================
interface periph_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int GW = $clog2(NUM_REQ);

  // Requester side, packed per requester
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*24-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ*4-1:0]  req_wstrb;
  logic [31:0]           req_rdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_err;

  // Downstream peripheral bus
  logic                  bus_valid;
  logic [23:0]           bus_addr;
  logic                  bus_write;
  logic [31:0]           bus_wdata;
  logic [3:0]            bus_wstrb;
  logic [31:0]           bus_rdata;
  logic                  bus_ready;

  logic [GW-1:0]         grant_id;

  // Arbiter view
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
    output req_rdata, req_ready, req_err,
    output bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb,
    input  bus_rdata, bus_ready,
    output grant_id
  );

  // Environment view: requesters plus downstream peripheral
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb,
    input  req_rdata, req_ready, req_err,
    input  bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb,
    output bus_rdata, bus_ready,
    input  grant_id
  );
endinterface
`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : periph_bus_arbiter
// Purpose  : round-robin sharing of one peripheral bus with per-transaction timeout
// Revision : 1.0
// ============================================================================
module periph_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  periph_bus_arbiter_if.master bus_if
);
  localparam int          GW        = $clog2(NUM_REQ);
  // Last BUSY cycle index before the counter would reach TIMEOUT
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 bus_valid_q, bus_valid_d;
  logic [23:0]          bus_addr_q, bus_addr_d;
  logic                 bus_write_q, bus_write_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic [3:0]           bus_wstrb_q, bus_wstrb_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [23:0]          addr_arr  [NUM_REQ];
  logic                 write_arr [NUM_REQ];
  logic [31:0]          wdata_arr [NUM_REQ];
  logic [3:0]           wstrb_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   grant_oh;

  logic [GW-1:0]        cand;
  logic [GW-1:0]        pick;
  logic                 pick_found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus_if.req_addr[24*i +: 24];
    assign write_arr[i] = bus_if.req_write[i];
    assign wdata_arr[i] = bus_if.req_wdata[32*i +: 32];
    assign wstrb_arr[i] = bus_if.req_wstrb[4*i +: 4];
    assign grant_oh[i]  = (grant_q == GW'(i));
  end

  // Descending scan so the candidate closest after grant_q is assigned last and wins
  always_comb begin
    cand       = grant_q;
    pick       = grant_q;
    pick_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(grant_q) + k) % NUM_REQ);
      if (bus_if.req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_write_d = bus_write_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    cnt_d       = cnt_q;
    ready_d     = '0;
    err_d       = '0;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick;
          bus_valid_d = 1'b1;
          bus_addr_d  = addr_arr[pick];
          bus_write_d = write_arr[pick];
          bus_wdata_d = wdata_arr[pick];
          bus_wstrb_d = wstrb_arr[pick];
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        // A completion in the timeout cycle still counts as a normal completion
        if (bus_if.bus_ready) begin
          bus_valid_d = 1'b0;
          ready_d     = grant_oh;
          rdata_d     = bus_if.bus_rdata;
          state_d     = DONE;
        end else if (cnt_q == C_TO_LAST) begin
          bus_valid_d = 1'b0;
          ready_d     = grant_oh;
          err_d       = grant_oh;
          rdata_d     = 32'h0000_0000;
          state_d     = DONE;
        end
      end
      DONE: begin
        cnt_d   = 16'd0;
        state_d = IDLE;
      end
      default: begin
        bus_valid_d = 1'b0;
        cnt_d       = 16'd0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= GW'(NUM_REQ - 1);
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 24'h0;
      bus_write_q <= 1'b0;
      bus_wdata_q <= 32'h0;
      bus_wstrb_q <= 4'h0;
      cnt_q       <= 16'd0;
      ready_q     <= '0;
      err_q       <= '0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_write_q <= bus_write_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_if.bus_valid = bus_valid_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_write = bus_write_q;
  assign bus_if.bus_wdata = bus_wdata_q;
  assign bus_if.bus_wstrb = bus_wstrb_q;
  assign bus_if.req_ready = ready_q;
  assign bus_if.req_err   = err_q;
  assign bus_if.req_rdata = rdata_q;
  assign bus_if.grant_id  = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_bus_arbiter
// Purpose  : scoreboard bench for periph_bus_arbiter (NUM_REQ=2, TIMEOUT=8)
// Revision : 1.0
// ============================================================================
module tb_periph_bus_arbiter;
  localparam int NR = 2;
  localparam int TO = 8;
  localparam int AW = NR * 24;
  localparam int DW = NR * 32;
  localparam int SW = NR * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  periph_bus_arbiter_if #(.NUM_REQ(NR)) bif ();

  periph_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus_if  (bif.master)
  );

  typedef struct { int id; logic [23:0] addr; logic wr; logic [31:0] wdata; logic [3:0] wstrb; } bus_exp_t;
  typedef struct { int id; logic [31:0] rdata; logic err; } rsp_exp_t;
  typedef struct {
    int id; logic [23:0] addr; logic wr; logic [31:0] wdata; logic [3:0] wstrb;
    int delay; logic [31:0] rdata; logic err; int len;
  } vec_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  vec_t     tbl[5];

  int n_tests = 0;
  int n_fail  = 0;

  bit          bv_prev  = 1'b0;
  bit          seen_txn = 1'b0;
  int          bv_len = 0, last_bv_len = 0, gap = 0, last_gap = 0;
  logic [60:0] lat = '0;
  int          reissue_left[NR];
  int          dn_delay = 0, dn_cnt = 0;
  logic [31:0] dn_data = 32'h0;
  bit          dn_spurious = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic issue(input int id, input logic [23:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err);
    bus_exp_t b;
    rsp_exp_t r;
    bif.req_addr  = (bif.req_addr  & ~(AW'(24'hFF_FFFF) << (24*id)))   | (AW'(addr)  << (24*id));
    bif.req_wdata = (bif.req_wdata & ~(DW'(32'hFFFF_FFFF) << (32*id))) | (DW'(wdata) << (32*id));
    bif.req_wstrb = (bif.req_wstrb & ~(SW'(4'hF) << (4*id)))           | (SW'(wstrb) << (4*id));
    bif.req_write = (bif.req_write & ~(NR'(1) << id))                  | (NR'(wr)    << id);
    bif.req_valid = bif.req_valid | (NR'(1) << id);
    b = '{id, addr, wr, wdata, wstrb};
    r = '{id, exp_rdata, exp_err};
    bus_q.push_back(b);
    rsp_q.push_back(r);
  endtask

  task automatic monitor();
    logic [60:0]   cur;
    logic [NR-1:0] exp_rdy;
    bus_exp_t      b;
    rsp_exp_t      r;
    cur = {bif.bus_addr, bif.bus_write, bif.bus_wdata, bif.bus_wstrb};
    if (bif.bus_valid) begin
      if (!bv_prev) begin
        if (seen_txn) begin
          check("bus_valid_gap_ge2", 64'(gap >= 2), 64'd1);
          last_gap = gap;
        end
        if (bus_q.size() == 0) begin
          fail_now("grant", "bus_valid rose with no request expected");
        end else begin
          b = bus_q.pop_front();
          check("grant_id", 64'(bif.grant_id), 64'(b.id));
          check("bus_fields", 64'(cur), 64'({b.addr, b.wr, b.wdata, b.wstrb}));
        end
        lat    = cur;
        bv_len = 0;
      end else begin
        check("bus_hold", 64'(cur), 64'(lat));
      end
      bv_len++;
    end else begin
      if (bv_prev) begin
        last_bv_len = bv_len;
        seen_txn    = 1'b1;
        gap         = 0;
      end
      gap++;
    end
    bv_prev = bif.bus_valid;

    if (bif.req_ready != '0) begin
      if (rsp_q.size() == 0) begin
        fail_now("req_ready", "response with no request outstanding");
      end else begin
        r       = rsp_q.pop_front();
        exp_rdy = NR'(1) << r.id;
        check("req_ready", 64'(bif.req_ready), 64'(exp_rdy));
        check("req_err", 64'(bif.req_err), r.err ? 64'(exp_rdy) : 64'd0);
        check("req_rdata", 64'(bif.req_rdata), 64'(r.rdata));
      end
      for (int i = 0; i < NR; i++) begin
        if (((bif.req_ready >> i) & NR'(1)) != '0) begin
          if (reissue_left[i] > 0) begin
            reissue_left[i]--;
            issue(i, 24'h000300 + 24'(i * 4), 1'b1, 32'(32'h100 * (i + 1) + reissue_left[i]), 4'hF, dn_data, 1'b0);
          end else begin
            bif.req_valid = bif.req_valid & ~(NR'(1) << i);
          end
        end
      end
    end else if (bif.req_err != '0) begin
      fail_now("req_err", "error asserted without req_ready");
    end
  endtask

  // Downstream peripheral: acknowledges dn_delay cycles after bus_valid, never if negative
  task automatic downstream();
    if (bif.bus_valid) begin
      bif.bus_ready = (dn_delay >= 0 && dn_cnt == dn_delay);
      bif.bus_rdata = dn_data;
      dn_cnt++;
    end else begin
      dn_cnt        = 0;
      bif.bus_ready = dn_spurious;
      bif.bus_rdata = dn_spurious ? 32'hDEAD_BEEF : 32'h0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
    downstream();
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((rsp_q.size() != 0 || bif.bus_valid || bif.req_valid != '0) && cyc < 300) begin
      step();
      cyc++;
    end
    if (cyc >= 300) begin
      fail_now(name, "transaction did not complete within 300 cycles");
      bus_q.delete();
      rsp_q.delete();
      bif.req_valid = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reissue_left[0] = 0;
    reissue_left[1] = 0;
    bif.req_valid = '0;
    bif.req_addr  = '0;
    bif.req_write = '0;
    bif.req_wdata = '0;
    bif.req_wstrb = '0;
    bif.bus_rdata = '0;
    bif.bus_ready = 1'b0;

    //            id addr        wr    wdata         wstrb  dly rdata          err len
    tbl[0] = '{0, 24'h000040, 1'b0, 32'h0,         4'hF,  2, 32'hA5A5_0003, 1'b0, 3};
    tbl[1] = '{1, 24'h000104, 1'b1, 32'h1234_5678, 4'hF,  0, 32'h0000_1111, 1'b0, 1};
    tbl[2] = '{1, 24'h000200, 1'b0, 32'h0,         4'hF, -1, 32'h0000_0000, 1'b1, 8};
    tbl[3] = '{0, 24'h00FFFC, 1'b0, 32'h0,         4'hF,  7, 32'h5A5A_C3C3, 1'b0, 8};
    tbl[4] = '{1, 24'hFFFFFF, 1'b1, 32'h89AB_CDEF, 4'h2,  6, 32'h0000_2222, 1'b0, 7};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_valid", 64'(bif.bus_valid), 64'd0);
    check("rst_bus_fields", 64'({bif.bus_addr, bif.bus_write, bif.bus_wdata, bif.bus_wstrb}), 64'd0);
    check("rst_req_ready", 64'(bif.req_ready), 64'd0);
    check("rst_req_err", 64'(bif.req_err), 64'd0);
    check("rst_req_rdata", 64'(bif.req_rdata), 64'd0);
    check("rst_grant_id", 64'(bif.grant_id), 64'(NR - 1));
    rst_n = 1'b1;
    step();

    // Single transactions, including timeout and ready-in-timeout-cycle
    for (int k = 0; k < 5; k++) begin
      dn_delay = tbl[k].delay;
      dn_data  = tbl[k].err ? 32'hFFFF_FFFF : tbl[k].rdata;
      issue(tbl[k].id, tbl[k].addr, tbl[k].wr, tbl[k].wdata, tbl[k].wstrb, tbl[k].rdata, tbl[k].err);
      wait_idle($sformatf("vec%0d", k));
      check($sformatf("vec%0d_bus_valid_len", k), 64'(last_bv_len), 64'(tbl[k].len));
    end

    // bus_ready while idle must not produce a response or a bus cycle
    dn_spurious = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("spurious_ready_no_rsp", 64'(bif.req_ready), 64'd0);
      check("spurious_ready_no_bus", 64'(bif.bus_valid), 64'd0);
    end
    dn_spurious = 1'b0;
    step();

    // Contention: simultaneous pairs granted 0 then 1, twice
    dn_delay = 1;
    dn_data  = 32'h0000_00C0;
    for (int p = 0; p < 2; p++) begin
      issue(0, 24'h000010, 1'b1, 32'h0000_0001, 4'hF, 32'h0000_00C0, 1'b0);
      issue(1, 24'h000014, 1'b1, 32'h0000_0002, 4'hF, 32'h0000_00C0, 1'b0);
      wait_idle("contention");
      check("contention_gap", 64'(last_gap), 64'd2);
    end

    // Rotation: both keep requesting, grants must alternate 0,1,0,1,0,1
    dn_delay = 0;
    dn_data  = 32'h0000_0ABC;
    reissue_left[0] = 2;
    reissue_left[1] = 2;
    issue(0, 24'h000300, 1'b1, 32'h0000_0103, 4'hF, 32'h0000_0ABC, 1'b0);
    issue(1, 24'h000304, 1'b1, 32'h0000_0203, 4'hF, 32'h0000_0ABC, 1'b0);
    wait_idle("rotation");

    // Strobes held through BUSY even when the requester changes its fields
    dn_delay = 4;
    dn_data  = 32'h0BAD_F00D;
    issue(1, 24'h000808, 1'b1, 32'hCAFE_0002, 4'b0010, 32'h0BAD_F00D, 1'b0);
    cyc = 0;
    while (!bif.bus_valid && cyc < 10) begin
      step();
      cyc++;
    end
    if (!bif.bus_valid) fail_now("strobe_grant", "bus_valid never rose");
    bif.req_wstrb[7:4]  = 4'b1111;
    bif.req_wdata[63:32] = 32'hFFFF_FFFF;
    bif.req_addr[47:24]  = 24'h000000;
    step();
    check("strobe_after_change", 64'(bif.bus_wstrb), 64'(4'b0010));
    wait_idle("strobe");

    // Asynchronous reset during BUSY
    dn_delay = -1;
    issue(1, 24'h000C00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
    cyc = 0;
    while (!bif.bus_valid && cyc < 10) begin
      step();
      cyc++;
    end
    step();
    step();
    check("pre_reset_busy", 64'(bif.bus_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bus_valid", 64'(bif.bus_valid), 64'd0);
    check("async_rst_req_ready", 64'(bif.req_ready), 64'd0);
    check("async_rst_req_err", 64'(bif.req_err), 64'd0);
    check("async_rst_grant_id", 64'(bif.grant_id), 64'(NR - 1));
    check("async_rst_bus_addr", 64'(bif.bus_addr), 64'd0);
    bus_q.delete();
    rsp_q.delete();
    bif.req_valid = '0;
    bif.bus_ready = 1'b0;
    bv_prev  = 1'b0;
    seen_txn = 1'b0;
    dn_cnt   = 0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    dn_delay = 1;
    dn_data  = 32'h7777_0000;
    issue(0, 24'h000020, 1'b0, 32'h0, 4'hF, 32'h7777_0000, 1'b0);
    issue(1, 24'h000024, 1'b0, 32'h0, 4'hF, 32'h7777_0000, 1'b0);
    wait_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
